// File: rtl/user_key_debounce.sv
// user_key_debounce: synchronizes and debounces raw push-buttons into a clean level plus press/release pulses; USER_KEY_IRQ_EN adds a W1C pending register at 0x7f44 with an irq
module user_key_debounce #(
  parameter int WIDTH = 8,
  parameter int CNT_MAX = 250000,
  parameter int CNT_W = 18,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_stable,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  input  logic             we,
  output logic [31:0]      dataout,
  output logic             irq
);
  localparam logic [31:0] PEND_ADDR = 32'h0000_7f44;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);
  logic [WIDTH-1:0] n, sync1, sync2, flip, press_nxt, pending;
  logic unused_bits;
  assign n = ACTIVE_LOW ? ~key_raw : key_raw;
  assign press_nxt = flip & sync2;
  assign unused_bits = ^{din, we};
  // two-flop synchronizer, reset to released
  always_ff @(posedge clk)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= n;
      sync2 <= sync1;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    logic [CNT_W-1:0] cnt;
    assign flip[i] = (sync2[i] != key_stable[i]) && (cnt == LAST);
    // count consecutive samples disagreeing with the accepted level; any agreeing sample restarts it
    always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else cnt <= (sync2[i] == key_stable[i] || flip[i]) ? '0 : cnt + 1'b1;
  end
  // accept a settled change and emit its pulse on the same edge
  always_ff @(posedge clk)
    if (reset) begin
      key_stable <= '0;
      key_press <= '0;
      key_release <= '0;
    end else begin
      key_stable <= key_stable ^ flip;
      key_press <= press_nxt;
      key_release <= flip & ~sync2;
    end
`ifdef USER_KEY_IRQ_EN
  logic [WIDTH-1:0] clr;
  assign clr = (we && addr == PEND_ADDR) ? din[WIDTH-1:0] : '0;
  // latch presses (both the edge producing the pulse and the pulse cycle itself, so a clear then loses); irq lags pending by one
  always_ff @(posedge clk)
    if (reset) begin
      pending <= '0;
      irq <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press_nxt | key_press;
      irq <= |pending;
    end
`else
  assign pending = '0;
  assign irq = 1'b0;
`endif
  assign dataout = (addr == PEND_ADDR) ? 32'(pending) : '0;
endmodule

// File: tb/tb_user_key_debounce.sv
// tb_user_key_debounce: directed scoreboard bench for user_key_debounce with CNT_MAX=4, active-low keys
module tb_user_key_debounce;
`ifdef USER_KEY_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  typedef struct {
    int cyc;
    string tag;
    logic [7:0] st, pr, rl, pend;
    logic ir;
  } exp_t;
  logic clk, reset, we, irq;
  logic [7:0] key_raw, key_stable, key_press, key_release;
  logic [31:0] addr, din, dataout;
  exp_t sb[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  user_key_debounce #(.WIDTH(8), .CNT_MAX(4), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .key_stable(key_stable),
    .key_press(key_press), .key_release(key_release), .addr(addr), .din(din),
    .we(we), .dataout(dataout), .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void want(int dc, string tag, logic [7:0] st, logic [7:0] pr, logic [7:0] rl, logic ir, logic [7:0] pend);
    exp_t e;
    e.cyc = cyc + dc;
    e.tag = tag;
    e.st = st;
    e.pr = pr;
    e.rl = rl;
    e.ir = IRQ ? ir : 1'b0;
    e.pend = pend;
    sb.push_back(e);
  endfunction
  task automatic check(exp_t e);
    logic [31:0] xd;
    xd = (IRQ && addr == 32'h0000_7f44) ? {24'h0, e.pend} : 32'h0;
    n_chk++;
    assert (key_stable === e.st) else begin n_fail++; $error("FAIL %s key_stable cyc %0d got %h want %h", e.tag, cyc, key_stable, e.st); end
    n_chk++;
    assert (key_press === e.pr) else begin n_fail++; $error("FAIL %s key_press cyc %0d got %h want %h", e.tag, cyc, key_press, e.pr); end
    n_chk++;
    assert (key_release === e.rl) else begin n_fail++; $error("FAIL %s key_release cyc %0d got %h want %h", e.tag, cyc, key_release, e.rl); end
    n_chk++;
    assert (dataout === xd) else begin n_fail++; $error("FAIL %s dataout cyc %0d got %h want %h", e.tag, cyc, dataout, xd); end
    if (e.ir !== 1'bx) begin
      n_chk++;
      assert (irq === e.ir) else begin n_fail++; $error("FAIL %s irq cyc %0d got %b want %b", e.tag, cyc, irq, e.ir); end
    end
  endtask
  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    key_raw = 8'hFF;
    addr = 32'h0000_7f44;
    din = '0;
    we = 1'b0;
    tick(3);
    want(0, "reset", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i <= 3; i++) want(i, "idle", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tick(3);
    key_raw = 8'hFE;
    want(5, "t1_wait", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    want(6, "t1_press", 8'h01, 8'h01, 8'h00, 1'b0, 8'h01);
    want(7, "t1_irq", 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
    tick(7);
    addr = 32'h0000_7f40;
    want(0, "t1_addr", 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
    tick(1);
    addr = 32'h0000_7f44;
    key_raw = 8'hFF;
    want(5, "r1_wait", 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
    want(6, "r1_rel", 8'h00, 8'h00, 8'h01, 1'b1, 8'h01);
    want(7, "r1_end", 8'h00, 8'h00, 8'h00, 1'b1, 8'h01);
    tick(7);
    we = 1'b1;
    din = 32'h1;
    want(0, "clr_wr", 8'h00, 8'h00, 8'h00, 1'b1, 8'h01);
    tick(1);
    we = 1'b0;
    din = '0;
    want(0, "clr_done", 8'h00, 8'h00, 8'h00, 1'bx, 8'h00);
    want(1, "clr_irq", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tick(1);
    for (int i = 1; i <= 22; i++) want(i, "bounce", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    key_raw = 8'hF7;
    tick(3);
    key_raw = 8'hFF;
    tick(2);
    repeat (3) begin
      key_raw = 8'hF7;
      tick(2);
      key_raw = 8'hFF;
      tick(1);
    end
    tick(8);
    key_raw = 8'hDB;
    want(5, "t3_wait", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    want(6, "t3_press", 8'h24, 8'h24, 8'h00, 1'b0, 8'h24);
    want(7, "t3_irq", 8'h24, 8'h00, 8'h00, 1'b1, 8'h24);
    tick(7);
    we = 1'b1;
    din = 32'h04;
    want(0, "t3_wr1", 8'h24, 8'h00, 8'h00, 1'b1, 8'h24);
    tick(1);
    we = 1'b0;
    din = '0;
    want(0, "t3_clr1", 8'h24, 8'h00, 8'h00, 1'b1, 8'h20);
    want(1, "t3_hold", 8'h24, 8'h00, 8'h00, 1'b1, 8'h20);
    tick(1);
    we = 1'b1;
    din = 32'h20;
    want(0, "t3_wr2", 8'h24, 8'h00, 8'h00, 1'b1, 8'h20);
    tick(1);
    we = 1'b0;
    din = '0;
    want(0, "t3_clr2", 8'h24, 8'h00, 8'h00, 1'bx, 8'h00);
    want(1, "t3_irq0", 8'h24, 8'h00, 8'h00, 1'b0, 8'h00);
    tick(1);
    key_raw = 8'hFF;
    want(6, "t3_rel", 8'h00, 8'h00, 8'h24, 1'b0, 8'h00);
    want(7, "t3_rel_end", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tick(8);
    key_raw = 8'hFD;
    want(6, "t4_press", 8'h02, 8'h02, 8'h00, 1'b0, 8'h02);
    tick(6);
    we = 1'b1;
    din = 32'h02;
    tick(1);
    we = 1'b0;
    din = '0;
    want(0, "t4_set_wins", 8'h02, 8'h00, 8'h00, 1'b1, 8'h02);
    tick(1);
    we = 1'b1;
    din = 32'hFF;
    addr = 32'h0000_7f40;
    want(0, "t4_other_rd", 8'h02, 8'h00, 8'h00, 1'b1, 8'h02);
    tick(1);
    we = 1'b0;
    din = '0;
    addr = 32'h0000_7f44;
    want(0, "t4_other_wr", 8'h02, 8'h00, 8'h00, 1'b1, 8'h02);
    key_raw = 8'hFF;
    want(6, "t4_rel", 8'h00, 8'h00, 8'h02, 1'b1, 8'h02);
    tick(8);
    key_raw = 8'hEF;
    tick(4);
    reset = 1'b1;
    want(0, "t5_cnt", 8'h00, 8'h00, 8'h00, 1'b1, 8'h02);
    tick(1);
    want(0, "t5_rst", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tick(1);
    reset = 1'b0;
    want(0, "t5_rst2", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) want(i, "t5_refill", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    want(6, "t5_press", 8'h10, 8'h10, 8'h00, 1'b0, 8'h10);
    want(7, "t5_after", 8'h10, 8'h00, 8'h00, 1'b1, 8'h10);
    tick(10);
    n_chk++;
    assert (sb.size() == 0) else begin n_fail++; $error("FAIL scoreboard_drain left %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
